// File: rtl/sdram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM-controller bridge:
// FSM state encoding, the read-timeout error word and address field widths.
package sdram_bridge_pkg;

  localparam int DATA_W    = 32;
  localparam int SEL_W     = DATA_W / 8;
  localparam int WB_ADR_W  = 32;
  localparam int SD_ADDR_W = 23;
  localparam int TAG_W     = SD_ADDR_W - 2;
  localparam int TMO_W     = 16;

  // Returned on wbs_dat_o when the controller never answers a read
  localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_MERGE    = 3'd3,
    ST_WR_ISSUE = 3'd4,
    ST_ACK      = 3'd5
  } state_t;

endpackage

// File: rtl/sdram_bridge_merge.sv
// Byte-lane merge for partial writes: selected lanes come from the Wishbone
// write word, the remaining lanes keep the word read back from the controller.
module sdram_bridge_merge
  import sdram_bridge_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] merged
);

  // Per-lane select between read-back and write data
  always_comb begin
    merged = old_data;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone classic slave that turns single-word accesses into requests for a
// simple SDRAM controller (pulse sd_in_valid, read data returned by
// sd_out_valid). Partial writes are done as read-modify-write. Reads that are
// never answered complete with an error word after RD_TIMEOUT cycles.
// Optional feature: define SDRAM_BRIDGE_PREFETCH_EN to add a one-entry read
// buffer that serves repeated reads of the last word without a controller trip.
module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter logic [7:0]       BASE_HI    = 8'h38,
  parameter logic [TMO_W-1:0] RD_TIMEOUT = 16'd1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [SEL_W-1:0]     wbs_sel_i,
  input  logic [WB_ADR_W-1:0]  wbs_adr_i,
  input  logic [DATA_W-1:0]    wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [DATA_W-1:0]    wbs_dat_o,
  output logic [SD_ADDR_W-1:0] sd_addr,
  output logic                 sd_rw,
  output logic [DATA_W-1:0]    sd_wdata,
  output logic                 sd_in_valid,
  input  logic                 sd_busy,
  input  logic [DATA_W-1:0]    sd_rdata,
  input  logic                 sd_out_valid,
  output logic                 timeout_err
);

  state_t             state_q, state_d;
  logic               we_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mrg_q;
  logic [DATA_W-1:0]  merged;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               req, full_wr, rd_done, tmo_hit;
  logic               pf_hit;
  logic [DATA_W-1:0]  pf_rd_data;
  logic               unused_adr;

  // Byte offset and bit 23 do not take part in decoding or addressing
  assign unused_adr = &{1'b0, wbs_adr_i[23], wbs_adr_i[1:0]};

  assign req     = (state_q == ST_IDLE) && wbs_cyc_i && wbs_stb_i &&
                   (wbs_adr_i[31:24] == BASE_HI);
  assign full_wr = wbs_we_i && (wbs_sel_i == {SEL_W{1'b1}});
  assign rd_done = (state_q == ST_RD_WAIT) && sd_out_valid;
  assign tmo_hit = (state_q == ST_RD_WAIT) && !sd_out_valid &&
                   (tmo_cnt_q == RD_TIMEOUT - 1'b1);

  sdram_bridge_merge u_merge (
    .old_data (mrg_q),
    .new_data (wdata_q),
    .sel      (sel_q),
    .merged   (merged)
  );

`ifdef SDRAM_BRIDGE_PREFETCH_EN
  logic              pf_vld_q;
  logic [TAG_W-1:0]  pf_tag_q;
  logic [DATA_W-1:0] pf_data_q;

  assign pf_hit     = pf_vld_q && (pf_tag_q == wbs_adr_i[22:2]);
  assign pf_rd_data = pf_data_q;

  // Buffer valid: set by a completed read, dropped when a read times out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_vld_q <= 1'b0;
    end else if (tmo_hit) begin
      pf_vld_q <= 1'b0;
    end else if (rd_done && !we_q) begin
      pf_vld_q <= 1'b1;
    end
  end

  // Buffer contents: refilled on reads, kept coherent with writes to its tag
  always_ff @(posedge clk) begin
    if (rd_done && !we_q) begin
      pf_tag_q  <= sd_addr[22:2];
      pf_data_q <= sd_rdata;
    end else if ((state_q == ST_WR_ISSUE) && sd_in_valid &&
                 (pf_tag_q == sd_addr[22:2])) begin
      pf_data_q <= sd_wdata;
    end
  end
`else
  assign pf_hit     = 1'b0;
  assign pf_rd_data = '0;
`endif

  // FSM state, sticky timeout flag, read-wait counter and request kind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timeout_err <= 1'b0;
      tmo_cnt_q   <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= (state_q == ST_RD_WAIT) ? tmo_cnt_q + 1'b1 : '0;
      if (tmo_hit) timeout_err <= 1'b1;
      if (req)     we_q        <= wbs_we_i;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (full_wr)                 state_d = ST_WR_ISSUE;
          else if (!wbs_we_i && pf_hit) state_d = ST_ACK;
          else                         state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: if (!sd_busy) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (sd_out_valid) state_d = we_q ? ST_MERGE : ST_ACK;
        else if (tmo_hit) state_d = ST_ACK;
      end
      ST_MERGE:    state_d = ST_WR_ISSUE;
      ST_WR_ISSUE: if (!sd_busy) state_d = ST_ACK;
      ST_ACK:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: request pulse waits for the controller to be free
  always_comb begin
    sd_in_valid = ((state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE)) && !sd_busy;
    wbs_ack_o   = (state_q == ST_ACK);
  end

  // Controller-facing address/op/data and Wishbone read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_addr   <= '0;
      sd_rw     <= 1'b0;
      sd_wdata  <= '0;
      wbs_dat_o <= '0;
    end else begin
      if (req) begin
        sd_addr <= {wbs_adr_i[22:2], 2'b00};
        sd_rw   <= full_wr;
        if (full_wr) sd_wdata <= wbs_dat_i;
        if (!wbs_we_i && pf_hit) wbs_dat_o <= pf_rd_data;
      end
      if (rd_done && !we_q) wbs_dat_o <= sd_rdata;
      if (tmo_hit)          wbs_dat_o <= ERR_WORD;
      if (state_q == ST_MERGE) begin
        sd_wdata <= merged;
        sd_rw    <= 1'b1;
      end
    end
  end

  // Request payload and read-back word held for the read-modify-write
  always_ff @(posedge clk) begin
    if (req) begin
      sel_q   <= wbs_sel_i;
      wdata_q <= wbs_dat_i;
    end
    if (rd_done && we_q) mrg_q <= sd_rdata;
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench for sdram_wb_bridge with a small behavioural SDRAM controller
// that answers reads four cycles after the request (or never, on demand).
module tb_sdram_wb_bridge;

  localparam logic [15:0] TMO = 16'd40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [22:0] sd_addr;
  logic        sd_rw, sd_in_valid, timeout_err;
  logic [31:0] sd_wdata;
  logic        sd_busy = 1'b0;
  logic [31:0] sd_rdata = '0;
  logic        sd_out_valid = 1'b0;

  int n_chk = 0, n_fail = 0;
  int n_iss = 0, n_viol = 0;
  bit no_resp = 1'b0;
  logic        last_rw;
  logic [22:0] last_addr;
  logic [31:0] last_wd;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  sdram_wb_bridge #(.BASE_HI(8'h38), .RD_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .sd_addr      (sd_addr),
    .sd_rw        (sd_rw),
    .sd_wdata     (sd_wdata),
    .sd_in_valid  (sd_in_valid),
    .sd_busy      (sd_busy),
    .sd_rdata     (sd_rdata),
    .sd_out_valid (sd_out_valid),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Controller model, sampled mid-cycle after all stimulus has settled
  initial begin
    int cd;
    logic [5:0] pend;
    cd = 0;
    pend = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      #2;
      sd_out_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sd_out_valid = 1'b1;
          sd_rdata = mem[pend];
        end
      end
      if (sd_in_valid) begin
        n_iss++;
        if (sd_busy) n_viol++;
        last_rw = sd_rw;
        last_addr = sd_addr;
        last_wd = sd_wdata;
        if (sd_rw) mem[sd_addr[7:2]] = sd_wdata;
        else if (!no_resp) begin
          cd = 4;
          pend = sd_addr[7:2];
        end
      end
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int max_cyc,
                         output logic [31:0] rd, output int lat, output bit acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat = 0; acked = 1'b0; rd = '0;
    while (!acked && lat < max_cyc) begin
      @(negedge clk);
      lat++;
      if (ack) begin
        acked = 1'b1;
        rd = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Present a read for exactly the acceptance cycle, then drop the cycle
  task automatic wb_pulse_read(input logic [31:0] a);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic count_acks(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (ack) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, base, nack;
    bit acked;

    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_inv", sd_in_valid, 0);
    chk("rst_rw", sd_rw, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_addr", sd_addr, 0);
    chk("rst_wd", sd_wdata, 0);
    rst_n = 1'b1;
    count_acks(3, nack);
    chk("rst_noack", nack, 0);

    // Full write
    base = n_iss;
    wb_xfer(1, 32'h3800_0010, 32'h1122_3344, 4'hF, 50, rd, lat, acked);
    chk("fw_ack", acked, 1);
    chk("fw_lat", lat, 2);
    chk("fw_iss", n_iss - base, 1);
    chk("fw_rw", last_rw, 1);
    chk("fw_addr", last_addr, 23'h10);
    chk("fw_wd", last_wd, 32'h1122_3344);

    // Read back through the controller
    base = n_iss;
    wb_xfer(0, 32'h3800_0010, 0, 4'hF, 50, rd, lat, acked);
    chk("rd_ack", acked, 1);
    chk("rd_dat", rd, 32'h1122_3344);
    chk("rd_lat", lat, 6);
    chk("rd_iss", n_iss - base, 1);
    chk("rd_rw", last_rw, 0);

    // Repeat read: served from the buffer when it exists
    base = n_iss;
    wb_xfer(0, 32'h3800_0010, 0, 4'hF, 50, rd, lat, acked);
    chk("rd2_dat", rd, 32'h1122_3344);
`ifdef SDRAM_BRIDGE_PREFETCH_EN
    chk("rd2_lat", lat, 1);
    chk("rd2_iss", n_iss - base, 0);
`else
    chk("rd2_lat", lat, 6);
    chk("rd2_iss", n_iss - base, 1);
`endif

    // Partial write of byte 1
    base = n_iss;
    wb_xfer(1, 32'h3800_0010, 32'h0000_AA00, 4'b0010, 50, rd, lat, acked);
    chk("pw_ack", acked, 1);
    chk("pw_lat", lat, 8);
    chk("pw_iss", n_iss - base, 2);
    chk("pw_rw", last_rw, 1);
    chk("pw_wd", last_wd, 32'h1122_AA44);

    base = n_iss;
    wb_xfer(0, 32'h3800_0010, 0, 4'hF, 50, rd, lat, acked);
    chk("pwrd_dat", rd, 32'h1122_AA44);
`ifdef SDRAM_BRIDGE_PREFETCH_EN
    chk("pwrd_iss", n_iss - base, 0);
`else
    chk("pwrd_iss", n_iss - base, 1);
`endif

    // sel==0 still reads and rewrites the unchanged word
    wb_xfer(1, 32'h3800_0020, 32'hCAFE_F00D, 4'hF, 50, rd, lat, acked);
    base = n_iss;
    wb_xfer(1, 32'h3800_0020, 32'hFFFF_FFFF, 4'h0, 50, rd, lat, acked);
    chk("s0_ack", acked, 1);
    chk("s0_iss", n_iss - base, 2);
    chk("s0_wd", last_wd, 32'hCAFE_F00D);
    chk("s0_addr", last_addr, 23'h20);

    // Controller busy for 10 cycles while the read waits to issue
    base = n_iss;
    sd_busy = 1'b1;
    fork
      wb_xfer(0, 32'h3800_0020, 0, 4'hF, 80, rd, lat, acked);
      begin
        repeat (10) @(negedge clk);
        sd_busy = 1'b0;
      end
    join
    chk("bz_ack", acked, 1);
    chk("bz_viol", n_viol, 0);
    chk("bz_iss", n_iss - base, 1);
    chk("bz_dat", rd, 32'hCAFE_F00D);

    // Address outside the window
    base = n_iss;
    wb_xfer(0, 32'h3900_0000, 0, 4'hF, 20, rd, lat, acked);
    chk("oow_ack", acked, 0);
    chk("oow_iss", n_iss - base, 0);

    // Read never answered
    no_resp = 1'b1;
    wb_xfer(0, 32'h3800_0040, 0, 4'hF, int'(TMO) + 20, rd, lat, acked);
    no_resp = 1'b0;
    chk("to_ack", acked, 1);
    chk("to_dat", rd, 32'hDEAD_BEEF);
    chk("to_err", timeout_err, 1);
    chk("to_lat", lat, int'(TMO) + 2);

    // After a timeout the buffer holds nothing, so this goes to the controller
    base = n_iss;
    wb_xfer(0, 32'h3800_0020, 0, 4'hF, 50, rd, lat, acked);
    chk("pto_iss", n_iss - base, 1);
    chk("pto_dat", rd, 32'hCAFE_F00D);
    chk("pto_sticky", timeout_err, 1);

    // Cycle dropped right after acceptance still completes
    wb_pulse_read(32'h3800_0010);
    count_acks(12, nack);
    chk("drop_acks", nack, 1);
    chk("drop_dat", dat_o, 32'h1122_AA44);

    // Reset while waiting for read data
    no_resp = 1'b1;
    wb_pulse_read(32'h3800_0080);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_resp = 1'b0;
    count_acks(int'(TMO) + 10, nack);
    chk("rrst_acks", nack, 0);
    chk("rrst_err", timeout_err, 0);
    chk("rrst_dat", dat_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
